// File: rtl/motion_bbox_pkg.sv
// Shared widths and FSM encoding for the motion bounding-box tracker.
package motion_bbox_pkg;

    localparam int COORD_W = 10;
    localparam int CNT_W   = 19;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        IN_FRAME   = 2'd1,
        REPORT     = 2'd2
    } state_t;

endpackage

// File: rtl/motion_bbox_axis_tracker.sv
// Running min/max of one coordinate axis; clr restarts the search, upd folds in coord.
module bbox_axis_tracker
    import motion_bbox_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               upd,
    input  logic [COORD_W-1:0] coord,
    output logic [COORD_W-1:0] min_val,
    output logic [COORD_W-1:0] max_val
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_val <= {COORD_W{1'b1}};
            max_val <= '0;
        end else if (clr) begin
            min_val <= {COORD_W{1'b1}};
            max_val <= '0;
        end else if (upd) begin
            if (coord < min_val) min_val <= coord;
            if (coord > max_val) max_val <= coord;
        end
    end

endmodule

// File: rtl/motion_bbox.sv
// Bounding box of foreground pixels in a binary frame, reported once per frame.
// Build option: BBOX_MIN_AREA_EN requires at least MIN_PIXELS foreground pixels for box_found.
module motion_bbox
    import motion_bbox_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP  = 10'd640,
    parameter logic [COORD_W-1:0] IMG_VDISP  = 10'd480,
    parameter logic [CNT_W-1:0]   MIN_PIXELS = 19'd64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dilation_vsync,
    input  logic               dilation_href,
    input  logic               dilation_clken,
    input  logic               dilation_img_Bit,
    output logic [COORD_W-1:0] box_x_min,
    output logic [COORD_W-1:0] box_x_max,
    output logic [COORD_W-1:0] box_y_min,
    output logic [COORD_W-1:0] box_y_max,
    output logic [CNT_W-1:0]   box_pixel_cnt,
    output logic               box_found,
    output logic               box_valid,
    output logic [1:0]         dbg_state
);

`ifdef BBOX_MIN_AREA_EN
    localparam bit MIN_AREA_EN = 1'b1;
`else
    localparam bit MIN_AREA_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] FOUND_THRESH = MIN_AREA_EN ? MIN_PIXELS : CNT_W'(1);

    state_t             state, state_nxt;
    logic               vsync_d, href_d;
    logic               vsync_rise, vsync_fall, href_fall;
    logic               frame_clr, in_px, pix_fg, found;
    logic               x_full, y_full;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic [COORD_W-1:0] x_min, x_max, y_min, y_max;
    logic [CNT_W-1:0]   pix_cnt;

    assign vsync_rise = dilation_vsync & ~vsync_d;
    assign vsync_fall = ~dilation_vsync & vsync_d;
    assign href_fall  = ~dilation_href & href_d;
    assign in_px      = (state == IN_FRAME) & dilation_vsync & dilation_href & dilation_clken;
    assign pix_fg     = in_px & dilation_img_Bit & ~x_full & ~y_full;
    assign found      = (pix_cnt >= FOUND_THRESH);

    // box_valid is a one-cycle strobe with no back-pressure: box_* are stable from that
    // cycle until the next strobe, so a consumer samples them whenever box_valid is high.
    assign box_valid  = (state == REPORT);
    assign dbg_state  = state;

    // vsync_d resets high so a frame already in progress at reset release never looks like a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_FRAME;
            vsync_d <= 1'b1;
            href_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_d <= dilation_vsync;
            href_d  <= dilation_href;
        end
    end

    always_comb begin
        state_nxt = state;
        frame_clr = 1'b0;
        case (state)
            WAIT_FRAME: if (vsync_rise) state_nxt = IN_FRAME;
            IN_FRAME:   if (vsync_fall) state_nxt = REPORT;
            REPORT:     state_nxt = vsync_rise ? IN_FRAME : WAIT_FRAME;
            default:    state_nxt = WAIT_FRAME;
        endcase
        if (vsync_rise && state != IN_FRAME) frame_clr = 1'b1;
    end

    // Columns/lines past the last valid one latch a full flag rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt  <= '0;
            x_full <= 1'b0;
        end else if (frame_clr || href_fall) begin
            x_cnt  <= '0;
            x_full <= 1'b0;
        end else if (in_px && !x_full) begin
            if (x_cnt == IMG_HDISP - 10'd1) x_full <= 1'b1;
            else                            x_cnt  <= x_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_cnt  <= '0;
            y_full <= 1'b0;
        end else if (frame_clr) begin
            y_cnt  <= '0;
            y_full <= 1'b0;
        end else if (state == IN_FRAME && href_fall && !y_full) begin
            if (y_cnt == IMG_VDISP - 10'd1) y_full <= 1'b1;
            else                            y_cnt  <= y_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                pix_cnt <= '0;
        else if (frame_clr)                        pix_cnt <= '0;
        else if (pix_fg && pix_cnt != {CNT_W{1'b1}}) pix_cnt <= pix_cnt + CNT_W'(1);
    end

    bbox_axis_tracker u_x_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (frame_clr),
        .upd     (pix_fg),
        .coord   (x_cnt),
        .min_val (x_min),
        .max_val (x_max)
    );

    bbox_axis_tracker u_y_trk (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (frame_clr),
        .upd     (pix_fg),
        .coord   (y_cnt),
        .min_val (y_min),
        .max_val (y_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x_min     <= '0;
            box_x_max     <= '0;
            box_y_min     <= '0;
            box_y_max     <= '0;
            box_pixel_cnt <= '0;
            box_found     <= 1'b0;
        end else if (state == IN_FRAME && vsync_fall) begin
            box_found     <= found;
            box_pixel_cnt <= pix_cnt;
            box_x_min     <= found ? x_min : '0;
            box_x_max     <= found ? x_max : '0;
            box_y_min     <= found ? y_min : '0;
            box_y_max     <= found ? y_max : '0;
        end
    end

endmodule

// File: tb/tb_motion_bbox.sv
// Directed bench for motion_bbox with a 16x8 image and MIN_PIXELS=4.
module tb_motion_bbox;

    localparam logic [9:0]  HD   = 10'd16;
    localparam logic [9:0]  VD   = 10'd8;
    localparam logic [18:0] MINP = 19'd4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic vsync = 1'b0, href = 1'b0, clken = 1'b0, bit_i = 1'b0;
    logic [9:0]  box_x_min, box_x_max, box_y_min, box_y_max;
    logic [18:0] box_pixel_cnt;
    logic        box_found, box_valid;
    logic [1:0]  dbg_state;

    int checks = 0, errors = 0, pulse_cnt = 0;
    logic [31:0] img [0:7];
    logic [9:0]  e_xmin, e_xmax, e_ymin, e_ymax;
    logic [18:0] e_cnt;
    logic        e_found;

    motion_bbox #(.IMG_HDISP(HD), .IMG_VDISP(VD), .MIN_PIXELS(MINP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dilation_vsync   (vsync),
        .dilation_href    (href),
        .dilation_clken   (clken),
        .dilation_img_Bit (bit_i),
        .box_x_min        (box_x_min),
        .box_x_max        (box_x_max),
        .box_y_min        (box_y_min),
        .box_y_max        (box_y_max),
        .box_pixel_cnt    (box_pixel_cnt),
        .box_found        (box_found),
        .box_valid        (box_valid),
        .dbg_state        (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) if (box_valid === 1'b1) pulse_cnt++;

    // driver tasks
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_img();
        for (int i = 0; i < 8; i++) img[i] = '0;
    endtask

    task automatic drive_line(input int y, input int npix, input logic gap);
        for (int x = 0; x < npix; x++) begin
            href = 1'b1; clken = 1'b1; bit_i = img[y][x]; tick();
            if (gap) begin clken = 1'b0; bit_i = 1'b1; tick(); end
        end
        href = 1'b0; clken = 1'b0; bit_i = 1'b0; tick(); tick();
    endtask

    task automatic send_frame(input int nlines, input int npix, input logic gap);
        vsync = 1'b1; tick(); tick();
        for (int y = 0; y < nlines; y++) drive_line(y, npix, gap);
    endtask

    task automatic end_frame(input string tag, input logic expect_pulse);
        vsync = 1'b0; href = 1'b0; clken = 1'b0;
        @(negedge clk);
        checks++; if (box_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_early got %b want 0", tag, box_valid); end
        @(negedge clk);
        checks++; if (box_valid !== expect_pulse) begin errors++; $display("FAIL %s_valid_pulse got %b want %b", tag, box_valid, expect_pulse); end
        @(negedge clk);
        checks++; if (box_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_width got %b want 0", tag, box_valid); end
        tick(); tick();
    endtask

    // expected-value model: found rule then bounds zeroed when not found
    task automatic set_expect(input int xmin, input int xmax, input int ymin, input int ymax, input int cnt);
`ifdef BBOX_MIN_AREA_EN
        e_found = (cnt >= int'(MINP));
`else
        e_found = (cnt != 0);
`endif
        e_cnt  = 19'(cnt);
        e_xmin = e_found ? 10'(xmin) : 10'd0;
        e_xmax = e_found ? 10'(xmax) : 10'd0;
        e_ymin = e_found ? 10'(ymin) : 10'd0;
        e_ymax = e_found ? 10'(ymax) : 10'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick(); tick();
        @(negedge clk);
        checks++; if (box_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", box_valid); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", dbg_state); end
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max} !== 40'd0) begin errors++; $display("FAIL rst_bounds got %h want 0", {box_x_min, box_x_max, box_y_min, box_y_max}); end
        checks++; if ({box_pixel_cnt, box_found} !== 20'd0) begin errors++; $display("FAIL rst_cnt_found got %h want 0", {box_pixel_cnt, box_found}); end
        tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_basic();
        pulse_cnt = 0; clear_img();
        img[2][3] = 1'b1; img[5][10] = 1'b1; img[7][7] = 1'b1;
        send_frame(8, 16, 1'b1);
        end_frame("basic", 1'b1);
        set_expect(3, 10, 2, 7, 3);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", pulse_cnt); end
        checks++; if (box_x_min !== e_xmin) begin errors++; $display("FAIL basic_xmin got %0d want %0d", box_x_min, e_xmin); end
        checks++; if (box_x_max !== e_xmax) begin errors++; $display("FAIL basic_xmax got %0d want %0d", box_x_max, e_xmax); end
        checks++; if (box_y_min !== e_ymin) begin errors++; $display("FAIL basic_ymin got %0d want %0d", box_y_min, e_ymin); end
        checks++; if (box_y_max !== e_ymax) begin errors++; $display("FAIL basic_ymax got %0d want %0d", box_y_max, e_ymax); end
        checks++; if (box_pixel_cnt !== e_cnt) begin errors++; $display("FAIL basic_cnt got %0d want %0d", box_pixel_cnt, e_cnt); end
        checks++; if (box_found !== e_found) begin errors++; $display("FAIL basic_found got %b want %b", box_found, e_found); end
    endtask

    task automatic test_empty();
        pulse_cnt = 0; clear_img();
        send_frame(8, 16, 1'b0);
        end_frame("empty", 1'b1);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL empty_pulses got %0d want 1", pulse_cnt); end
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max} !== 40'd0) begin errors++; $display("FAIL empty_bounds got %h want 0", {box_x_min, box_x_max, box_y_min, box_y_max}); end
        checks++; if (box_pixel_cnt !== 19'd0) begin errors++; $display("FAIL empty_cnt got %0d want 0", box_pixel_cnt); end
        checks++; if (box_found !== 1'b0) begin errors++; $display("FAIL empty_found got %b want 0", box_found); end
    endtask

    task automatic test_full();
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) img[i] = 32'h0000_FFFF;
        send_frame(8, 16, 1'b0);
        end_frame("full", 1'b1);
        set_expect(0, 15, 0, 7, 128);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL full_pulses got %0d want 1", pulse_cnt); end
        checks++; if ({box_x_min, box_x_max} !== {e_xmin, e_xmax}) begin errors++; $display("FAIL full_x got %0d..%0d want %0d..%0d", box_x_min, box_x_max, e_xmin, e_xmax); end
        checks++; if ({box_y_min, box_y_max} !== {e_ymin, e_ymax}) begin errors++; $display("FAIL full_y got %0d..%0d want %0d..%0d", box_y_min, box_y_max, e_ymin, e_ymax); end
        checks++; if (box_pixel_cnt !== e_cnt) begin errors++; $display("FAIL full_cnt got %0d want %0d", box_pixel_cnt, e_cnt); end
        checks++; if (box_found !== e_found) begin errors++; $display("FAIL full_found got %b want %b", box_found, e_found); end
    endtask

    task automatic test_saturate();
        pulse_cnt = 0; clear_img();
        img[0][15] = 1'b1; img[0][19] = 1'b1; img[1][2] = 1'b1;
        send_frame(2, 20, 1'b0);
        end_frame("sat", 1'b1);
        set_expect(2, 15, 0, 1, 2);
        checks++; if ({box_x_min, box_x_max} !== {e_xmin, e_xmax}) begin errors++; $display("FAIL sat_x got %0d..%0d want %0d..%0d", box_x_min, box_x_max, e_xmin, e_xmax); end
        checks++; if ({box_y_min, box_y_max} !== {e_ymin, e_ymax}) begin errors++; $display("FAIL sat_y got %0d..%0d want %0d..%0d", box_y_min, box_y_max, e_ymin, e_ymax); end
        checks++; if (box_pixel_cnt !== e_cnt) begin errors++; $display("FAIL sat_cnt got %0d want %0d", box_pixel_cnt, e_cnt); end
        checks++; if (box_found !== e_found) begin errors++; $display("FAIL sat_found got %b want %b", box_found, e_found); end
    endtask

    task automatic test_back_to_back();
        pulse_cnt = 0; clear_img();
        img[1][4] = 1'b1;
        send_frame(3, 16, 1'b0);
        vsync = 1'b0; tick();
        vsync = 1'b1;
        @(negedge clk);
        set_expect(4, 4, 1, 1, 1);
        checks++; if (box_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", box_valid); end
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {e_xmin, e_xmax, e_ymin, e_ymax}) begin errors++; $display("FAIL b2b_first_bounds got %h want %h", {box_x_min, box_x_max, box_y_min, box_y_max}, {e_xmin, e_xmax, e_ymin, e_ymax}); end
        tick(); tick();
        clear_img(); img[6][9] = 1'b1;
        for (int y = 0; y < 8; y++) drive_line(y, 16, 1'b0);
        end_frame("b2b", 1'b1);
        set_expect(9, 9, 6, 6, 1);
        checks++; if (pulse_cnt !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulse_cnt); end
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {e_xmin, e_xmax, e_ymin, e_ymax}) begin errors++; $display("FAIL b2b_second_bounds got %h want %h", {box_x_min, box_x_max, box_y_min, box_y_max}, {e_xmin, e_xmax, e_ymin, e_ymax}); end
        checks++; if (box_pixel_cnt !== e_cnt) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", box_pixel_cnt, e_cnt); end
    endtask

    task automatic test_reset_release_vsync_high();
        pulse_cnt = 0; clear_img();
        img[0][1] = 1'b1; img[1][1] = 1'b1;
        vsync = 1'b1; rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1; tick();
        for (int y = 0; y < 3; y++) drive_line(y, 16, 1'b0);
        end_frame("rel_partial", 1'b0);
        clear_img(); img[5][5] = 1'b1;
        send_frame(8, 16, 1'b0);
        end_frame("rel_full", 1'b1);
        set_expect(5, 5, 5, 5, 1);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL rel_pulses got %0d want 1", pulse_cnt); end
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {e_xmin, e_xmax, e_ymin, e_ymax}) begin errors++; $display("FAIL rel_bounds got %h want %h", {box_x_min, box_x_max, box_y_min, box_y_max}, {e_xmin, e_xmax, e_ymin, e_ymax}); end
        checks++; if (box_pixel_cnt !== e_cnt) begin errors++; $display("FAIL rel_cnt got %0d want %0d", box_pixel_cnt, e_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) img[i] = 32'h0000_0F0F;
        send_frame(2, 16, 1'b0);
        href = 1'b1; clken = 1'b1; bit_i = 1'b1; tick(); tick();
        rst_n = 1'b0; href = 1'b0; clken = 1'b0; bit_i = 1'b0;
        @(negedge clk);
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max, box_pixel_cnt, box_found} !== 60'd0) begin errors++; $display("FAIL mid_rst_outputs got %h want 0", {box_x_min, box_x_max, box_y_min, box_y_max, box_pixel_cnt, box_found}); end
        tick(); rst_n = 1'b1; tick();
        for (int y = 3; y < 6; y++) drive_line(y, 16, 1'b0);
        end_frame("mid_abort", 1'b0);
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max, box_pixel_cnt, box_found} !== 60'd0) begin errors++; $display("FAIL mid_after_abort got %h want 0", {box_x_min, box_x_max, box_y_min, box_y_max, box_pixel_cnt, box_found}); end
        clear_img(); img[0][0] = 1'b1; img[7][15] = 1'b1;
        send_frame(8, 16, 1'b0);
        end_frame("mid_next", 1'b1);
        set_expect(0, 15, 0, 7, 2);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL mid_pulses got %0d want 1", pulse_cnt); end
        checks++; if ({box_x_min, box_x_max, box_y_min, box_y_max} !== {e_xmin, e_xmax, e_ymin, e_ymax}) begin errors++; $display("FAIL mid_bounds got %h want %h", {box_x_min, box_x_max, box_y_min, box_y_max}, {e_xmin, e_xmax, e_ymin, e_ymax}); end
        checks++; if ({box_pixel_cnt, box_found} !== {e_cnt, e_found}) begin errors++; $display("FAIL mid_cnt_found got %h want %h", {box_pixel_cnt, box_found}, {e_cnt, e_found}); end
    endtask

    initial begin
        clear_img();
        test_reset();
        test_basic();
        test_empty();
        test_full();
        test_saturate();
        test_back_to_back();
        test_reset_release_vsync_high();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
